// File: rtl/xgxs_lane_sync_ctrl_if.sv
// Lane-sync controller bus: decoder/aligner status in, sync status and error count out.
// master drives the decoded code-group stream; slave is the sync controller.
interface xgxs_lane_sync_ctrl_if #(
    parameter int ERR_W = 16
);
    logic             cg_valid;
    logic             dec_code_viol;
    logic             dec_konstant_rx;
    logic             rx_comma;
    logic             err_clr;
    logic             sync_status;
    logic             enable_cgalign;
    logic             disp_rst;
    logic             sync_lost;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output cg_valid, dec_code_viol, dec_konstant_rx, rx_comma, err_clr,
        input  sync_status, enable_cgalign, disp_rst, sync_lost, err_cnt
    );

    modport slave (
        input  cg_valid, dec_code_viol, dec_konstant_rx, rx_comma, err_clr,
        output sync_status, enable_cgalign, disp_rst, sync_lost, err_cnt
    );
endinterface

// File: rtl/xgxs_lane_sync_ctrl.sv
// XGXS per-lane code-group synchronization FSM: comma detect, sync acquire/loss
// with good-group hysteresis, aligner gating, disparity reset and violation count.
module xgxs_lane_sync_ctrl #(
    parameter int ERR_W    = 16,
    parameter int GOOD_CNT = 4
) (
    input logic                  clk,
    input logic                  rst,
    xgxs_lane_sync_ctrl_if.slave lane
);
    typedef enum logic [2:0] {LOS, CD1, CD2, CD3, SA1, SA2, SA3, SA4} state_t;

    localparam logic [3:0] GOOD_LAST = 4'(GOOD_CNT - 1);

    state_t           state_p0;
    state_t           st_nxt;
    logic [3:0]       good_cgs_p0;
    logic [3:0]       good_nxt;
    logic [ERR_W-1:0] err_cnt_p0;
    logic             sync_status_p0;
    logic             enable_cgalign_p0;
    logic             disp_rst_p0;
    logic             sync_lost_p0;
    logic             is_inv;
    logic             is_comma;

    function automatic logic in_sync(input state_t s);
        return (s == SA1) || (s == SA2) || (s == SA3) || (s == SA4);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign is_inv   = lane.cg_valid & lane.dec_code_viol;
    assign is_comma = lane.cg_valid & lane.rx_comma & lane.dec_konstant_rx & ~lane.dec_code_viol;

    // Next state; good_cgs only ever runs in SA2..SA4 and is zeroed on every exit.
    always_comb begin
        st_nxt   = state_p0;
        good_nxt = good_cgs_p0;
        if (lane.cg_valid) begin
            unique case (state_p0)
                LOS: if (is_comma) st_nxt = CD1;
                CD1: if (is_inv) st_nxt = LOS; else if (is_comma) st_nxt = CD2;
                CD2: if (is_inv) st_nxt = LOS; else if (is_comma) st_nxt = CD3;
                CD3: if (is_inv) st_nxt = LOS; else if (is_comma) st_nxt = SA1;
                SA1: begin
                    good_nxt = 4'd0;
                    if (is_inv) st_nxt = SA2;
                end
                SA2, SA3, SA4: begin
                    if (is_inv) begin
                        good_nxt = 4'd0;
                        st_nxt   = (state_p0 == SA2) ? SA3 : (state_p0 == SA3) ? SA4 : LOS;
                    end else if (good_cgs_p0 == GOOD_LAST) begin
                        good_nxt = 4'd0;
                        st_nxt   = (state_p0 == SA2) ? SA1 : (state_p0 == SA3) ? SA2 : SA3;
                    end else begin
                        good_nxt = good_cgs_p0 + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0          <= LOS;
            good_cgs_p0       <= 4'd0;
            err_cnt_p0        <= '0;
            sync_status_p0    <= 1'b0;
            enable_cgalign_p0 <= 1'b1;
            disp_rst_p0       <= 1'b0;
            sync_lost_p0      <= 1'b0;
        end else begin
            state_p0          <= st_nxt;
            good_cgs_p0       <= good_nxt;
            sync_status_p0    <= in_sync(st_nxt);
            enable_cgalign_p0 <= (st_nxt == LOS);
            disp_rst_p0       <= (st_nxt == LOS) && (state_p0 != LOS);
            sync_lost_p0      <= (st_nxt == LOS) && (state_p0 == SA4);
            // Clear has priority over a coincident increment.
            if (lane.err_clr)
                err_cnt_p0 <= '0;
            else if (is_inv && in_sync(state_p0))
                err_cnt_p0 <= sat_inc(err_cnt_p0);
        end
    end

    assign lane.sync_status    = sync_status_p0;
    assign lane.enable_cgalign = enable_cgalign_p0;
    assign lane.disp_rst       = disp_rst_p0;
    assign lane.sync_lost      = sync_lost_p0;
    assign lane.err_cnt        = err_cnt_p0;
endmodule

// File: tb/tb_xgxs_lane_sync_ctrl.sv
// Directed bench for xgxs_lane_sync_ctrl (ERR_W=4, GOOD_CNT=4).
module tb_xgxs_lane_sync_ctrl;
    localparam int ERR_W = 4;
    localparam int GOOD_CNT = 4;
    localparam int K_COMMA = 0, K_DATA = 1, K_INV = 2, K_GAP = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    xgxs_lane_sync_ctrl_if #(.ERR_W(ERR_W)) bus ();

    xgxs_lane_sync_ctrl #(.ERR_W(ERR_W), .GOOD_CNT(GOOD_CNT)) dut (
        .clk  (clk),
        .rst  (rst),
        .lane (bus.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input int s, input int e, input int d, input int l, input int err);
        check({tag, ".sync"}, int'(bus.sync_status), s);
        check({tag, ".cgalign"}, int'(bus.enable_cgalign), e);
        check({tag, ".disp_rst"}, int'(bus.disp_rst), d);
        check({tag, ".sync_lost"}, int'(bus.sync_lost), l);
        check({tag, ".err"}, int'(bus.err_cnt), err);
    endtask

    // Present one group for one clock, then settle just after the edge.
    task automatic grp(input int kind);
        case (kind)
            K_COMMA: {bus.cg_valid, bus.dec_code_viol, bus.dec_konstant_rx, bus.rx_comma} = 4'b1011;
            K_DATA:  {bus.cg_valid, bus.dec_code_viol, bus.dec_konstant_rx, bus.rx_comma} = 4'b1000;
            K_INV:   {bus.cg_valid, bus.dec_code_viol, bus.dec_konstant_rx, bus.rx_comma} = 4'b1100;
            default: {bus.cg_valid, bus.dec_code_viol, bus.dec_konstant_rx, bus.rx_comma} = 4'b0111;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.err_clr = 1'b0;
        {bus.cg_valid, bus.dec_code_viol, bus.dec_konstant_rx, bus.rx_comma} = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        outs("reset", 0, 1, 0, 0, 0);
        rst = 1'b0;

        // Acquisition: C D C D C C
        grp(K_COMMA); outs("acq1", 0, 0, 0, 0, 0);
        grp(K_DATA);  check("acq2.sync", int'(bus.sync_status), 0);
        grp(K_COMMA); check("acq3.sync", int'(bus.sync_status), 0);
        grp(K_DATA);  check("acq4.sync", int'(bus.sync_status), 0);
        grp(K_COMMA); check("acq5.sync", int'(bus.sync_status), 0);
        grp(K_COMMA); outs("acq6", 1, 0, 0, 0, 0);

        // SA1 -> SA2 -> back to SA1 after GOOD_CNT valid groups
        grp(K_INV);   outs("rec_inv", 1, 0, 0, 0, 1);
        for (int i = 0; i < GOOD_CNT; i++) grp(K_DATA);
        outs("rec_good", 1, 0, 0, 0, 1);
        grp(K_INV);   outs("loss1", 1, 0, 0, 0, 2);
        grp(K_INV);   outs("loss2", 1, 0, 0, 0, 3);
        grp(K_INV);   outs("loss3", 1, 0, 0, 0, 4);
        grp(K_INV);   outs("loss4", 0, 1, 1, 1, 5);
        grp(K_DATA);  outs("loss_after", 0, 1, 0, 0, 5);
        grp(K_INV);   outs("los_inv", 0, 1, 0, 0, 5);

        // Clear, then abort during comma detect
        bus.err_clr = 1'b1;
        grp(K_DATA);  check("clr.err", int'(bus.err_cnt), 0);
        bus.err_clr = 1'b0;
        grp(K_COMMA); check("abort_c1.cgalign", int'(bus.enable_cgalign), 0);
        grp(K_COMMA);
        grp(K_INV);   outs("abort_inv", 0, 1, 1, 0, 0);
        grp(K_DATA);  check("abort_after.disp_rst", int'(bus.disp_rst), 0);
        grp(K_COMMA); grp(K_COMMA); grp(K_COMMA);
        check("abort_c3.sync", int'(bus.sync_status), 0);
        grp(K_COMMA); check("abort_c4.sync", int'(bus.sync_status), 1);

        // Gapped strobe: invalid-looking gaps must be ignored
        rst = 1'b1;
        grp(K_DATA);  outs("reset2", 0, 1, 0, 0, 0);
        rst = 1'b0;
        grp(K_COMMA); outs("gap_c1", 0, 0, 0, 0, 0);
        grp(K_GAP);   outs("gap_g1", 0, 0, 0, 0, 0);
        grp(K_DATA);
        grp(K_GAP);   outs("gap_g2", 0, 0, 0, 0, 0);
        grp(K_COMMA);
        grp(K_GAP);
        grp(K_DATA);
        grp(K_GAP);
        grp(K_COMMA);
        grp(K_GAP);   outs("gap_g5", 0, 0, 0, 0, 0);
        grp(K_COMMA); outs("gap_c4", 1, 0, 0, 0, 0);
        grp(K_GAP);   outs("gap_sync", 1, 0, 0, 0, 0);

        // Saturation at 2^ERR_W-1 = 15
        for (int n = 1; n <= 20; n++) begin
            grp(K_INV);
            check($sformatf("sat%0d.err", n), int'(bus.err_cnt), (n > 15) ? 15 : n);
            for (int i = 0; i < GOOD_CNT; i++) grp(K_DATA);
        end
        check("sat.sync", int'(bus.sync_status), 1);

        // Clear wins over a same-cycle increment
        bus.err_clr = 1'b1;
        grp(K_INV);   outs("clr_inv", 1, 0, 0, 0, 0);
        bus.err_clr = 1'b0;
        grp(K_DATA);  check("clr_after.err", int'(bus.err_cnt), 0);

        // Reset arriving with the 4th comma
        rst = 1'b1;
        grp(K_DATA);
        rst = 1'b0;
        grp(K_COMMA); grp(K_COMMA); grp(K_COMMA);
        check("rst_cd3.sync", int'(bus.sync_status), 0);
        rst = 1'b1;
        grp(K_COMMA); outs("rst_mid", 0, 1, 0, 0, 0);
        rst = 1'b0;
        grp(K_DATA);  outs("rst_after", 0, 1, 0, 0, 0);
        grp(K_COMMA); grp(K_COMMA); grp(K_COMMA);
        check("rst_re3.sync", int'(bus.sync_status), 0);
        grp(K_COMMA); check("rst_re4.sync", int'(bus.sync_status), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
